// File: rtl/loader_pkg.sv
// Shared encodings for the UART boot loader: FSM state codes, command bytes
// and the default load terminator word.
package loader_pkg;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_LOAD  = 3'd1;
    localparam logic [2:0] ST_WRITE = 3'd2;
    localparam logic [2:0] ST_RUN   = 3'd3;
    localparam logic [2:0] ST_STEP  = 3'd4;

    typedef enum logic [2:0] {
        IDLE  = ST_IDLE,
        LOAD  = ST_LOAD,
        WRITE = ST_WRITE,
        RUN   = ST_RUN,
        STEP  = ST_STEP
    } state_t;

    localparam logic [7:0] CMD_LOAD  = 8'h4C;
    localparam logic [7:0] CMD_RUN   = 8'h52;
    localparam logic [7:0] CMD_STEP  = 8'h53;
    localparam logic [7:0] CMD_PAUSE = 8'h50;

    localparam logic [31:0] END_WORD_DEF = 32'hFFFF_FFFF;

endpackage

// File: rtl/uart_loader_ctrl.sv
// Boot sequencer: assembles little-endian words from UART bytes into
// instruction memory, then gates the core clock-enable for run or single-step.
//
// state | meaning
// IDLE  | waiting for a command byte (L/R/S)
// LOAD  | shifting in bytes of the current word
// WRITE | one-cycle memory write or end-of-load decision
// RUN   | core enabled until halt or pause byte
// STEP  | core enabled for exactly one cycle
module uart_loader_ctrl
    import loader_pkg::*;
#(
    parameter int          ADDR_W   = 8,
    parameter logic [31:0] END_WORD = END_WORD_DEF
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              rx_done_tick,
    input  logic [7:0]        rx_data,
    input  logic              cpu_halt,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              cpu_enable,
    output logic              loaded,
    output logic              overflow,
    output logic              busy
);

    state_t            state_q, state_d;
    logic [31:0]       word_q;
    logic [1:0]        byte_cnt_q;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [31:0]       mem_wdata_q;
    logic              loaded_q, overflow_q;

    logic start_load, shift_byte, last_byte, set_loaded, set_overflow, addr_inc;
    logic is_end;

    assign is_end    = (mem_wdata_q == END_WORD);
    assign last_byte = (byte_cnt_q == 2'd3);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d      = state_q;
        start_load   = 1'b0;
        shift_byte   = 1'b0;
        set_loaded   = 1'b0;
        set_overflow = 1'b0;
        addr_inc     = 1'b0;
        case (state_q)
            IDLE: begin
                if (rx_done_tick) begin
                    if (rx_data == CMD_LOAD) begin
                        start_load = 1'b1;
                        state_d    = LOAD;
                    end else if (rx_data == CMD_RUN && loaded_q && !cpu_halt) begin
                        state_d = RUN;
                    end else if (rx_data == CMD_STEP && loaded_q && !cpu_halt) begin
                        state_d = STEP;
                    end
                end
            end
            LOAD: begin
                if (rx_done_tick) begin
                    shift_byte = 1'b1;
                    if (last_byte) state_d = WRITE;
                end
            end
            WRITE: begin
                // Terminator takes priority: a full memory ending in END_WORD is a clean load.
                if (is_end) begin
                    set_loaded = 1'b1;
                    state_d    = IDLE;
                end else if (addr_q == {ADDR_W{1'b1}}) begin
                    set_overflow = 1'b1;
                    state_d      = IDLE;
                end else begin
                    addr_inc = 1'b1;
                    state_d  = LOAD;
                end
            end
            RUN: begin
                if (cpu_halt || (rx_done_tick && rx_data == CMD_PAUSE)) state_d = IDLE;
            end
            STEP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            word_q      <= '0;
            byte_cnt_q  <= '0;
            addr_q      <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            loaded_q    <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            if (start_load) begin
                loaded_q   <= 1'b0;
                overflow_q <= 1'b0;
                addr_q     <= '0;
                byte_cnt_q <= '0;
            end
            if (shift_byte) begin
                word_q     <= {rx_data, word_q[31:8]};
                byte_cnt_q <= byte_cnt_q + 2'd1;
                // Output bus only moves when a word is complete, so it holds between writes.
                if (last_byte) begin
                    mem_wdata_q <= {rx_data, word_q[31:8]};
                    mem_addr_q  <= addr_q;
                end
            end
            if (set_loaded)   loaded_q   <= 1'b1;
            if (set_overflow) overflow_q <= 1'b1;
            if (addr_inc) begin
                addr_q     <= addr_q + 1'b1;
                byte_cnt_q <= '0;
            end
        end
    end

    assign mem_we     = (state_q == WRITE) && !is_end;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign cpu_enable = (state_q == RUN) || (state_q == STEP);
    assign loaded     = loaded_q;
    assign overflow   = overflow_q;
    assign busy       = (state_q != IDLE);

endmodule
